// File: rtl/j_term_skew_feeder_pkg.sv
// Shared types and helpers for the systolic column skew feeder.
package j_term_skew_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Ceiling log2, evaluated at elaboration time for counter widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Cycles needed to flush the last vector through the widest lane and the array rows.
  function automatic int unsigned drain_len(input int unsigned width, input int unsigned height);
    return width - 1 + height;
  endfunction

endpackage

// File: rtl/j_skew_lane.sv
// Registered delay line of DEPTH stages; DEPTH=0 degenerates to a wire.
module j_skew_lane #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign d_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift every cycle; the array never stalls so there is no enable.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int unsigned k = 0; k < DEPTH; k++) begin
            stage_q[k] <= '0;
          end
        end else begin
          stage_q[0] <= d_i;
          for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_q[k] <= stage_q[k-1];
          end
        end
      end

      assign d_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/j_term_skew_feeder.sv
// Skewed column feeder: captures one activation vector per accept and
// delays column i by i cycles before it reaches the systolic array.
module j_term_skew_feeder
  import j_term_skew_feeder_pkg::*;
#(
  parameter int unsigned SUBARRAY_WIDTH     = 8,
  parameter int unsigned SUBARRAY_HEIGHT    = 8,
  parameter int unsigned NUM_COMBINED_TERMS = 8,
  parameter int unsigned NUM_BIT_EXPONENT   = 4
) (
  input  logic                                                         clk,
  input  logic                                                         reset,
  input  logic                                                         in_valid,
  output logic                                                         in_ready,
  input  logic                                                         in_last,
  input  logic [NUM_COMBINED_TERMS*NUM_BIT_EXPONENT*SUBARRAY_WIDTH-1:0] in_exp,
  input  logic [NUM_COMBINED_TERMS*SUBARRAY_WIDTH-1:0]                  in_sign,
  output logic [NUM_COMBINED_TERMS*NUM_BIT_EXPONENT*SUBARRAY_WIDTH-1:0] dataflow_out,
  output logic [NUM_COMBINED_TERMS*SUBARRAY_WIDTH-1:0]                  sign_flow_out,
  output logic [SUBARRAY_WIDTH-1:0]                                     col_valid,
  output logic                                                         busy,
  output logic                                                         tile_done
);

  localparam int unsigned W   = SUBARRAY_WIDTH;
  localparam int unsigned T   = NUM_COMBINED_TERMS;
  localparam int unsigned TE  = NUM_COMBINED_TERMS * NUM_BIT_EXPONENT;
  localparam int unsigned LW  = 1 + T + TE;
  localparam int unsigned D   = drain_len(SUBARRAY_WIDTH, SUBARRAY_HEIGHT);
  localparam int unsigned CW  = (clog2(D + 1) < 1) ? 1 : clog2(D + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;

  logic            cap_valid_q;
  logic [TE*W-1:0] cap_exp_q;
  logic [T*W-1:0]  cap_sign_q;

  logic [LW-1:0]   lane_in  [W];
  logic [LW-1:0]   lane_out [W];

  assign accept = in_valid & in_ready;

  // State register and drain counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: open a tile on accept, enter drain on the last vector.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = ST_DRAIN;
            cnt_d   = CW'(D - 1);
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    in_ready  = (state_q != ST_DRAIN) & ~reset;
    busy      = (state_q != ST_IDLE);
    tile_done = (state_q == ST_DRAIN) && (cnt_q == '0);
  end

  // Capture stage shared by all lanes; a missing accept injects an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_valid_q <= 1'b0;
      cap_exp_q   <= '0;
      cap_sign_q  <= '0;
    end else if (accept) begin
      cap_valid_q <= 1'b1;
      cap_exp_q   <= in_exp;
      cap_sign_q  <= in_sign;
    end else begin
      cap_valid_q <= 1'b0;
      cap_exp_q   <= '0;
      cap_sign_q  <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_lane
      assign lane_in[gi] = {cap_valid_q, cap_sign_q[gi*T +: T], cap_exp_q[gi*TE +: TE]};

      // Lane 0 has no extra delay, so it bypasses the delay-line instance entirely.
      if (gi == 0) begin : g_direct
        assign lane_out[gi] = lane_in[gi];
      end else begin : g_delay
        j_skew_lane #(
          .DEPTH (gi),
          .WIDTH (LW)
        ) u_lane (
          .clk   (clk),
          .reset (reset),
          .d_i   (lane_in[gi]),
          .d_o   (lane_out[gi])
        );
      end

      assign dataflow_out[gi*TE +: TE] = lane_out[gi][TE-1:0];
      assign sign_flow_out[gi*T +: T]  = lane_out[gi][TE +: T];
      assign col_valid[gi]             = lane_out[gi][LW-1];
    end
  endgenerate

endmodule

// File: tb/tb_j_term_skew_feeder.sv
// Scoreboard bench for the column skew feeder (W=H=T=8, E=4).
module tb_j_term_skew_feeder;

  localparam int W  = 8;
  localparam int TE = 32;
  localparam int T  = 8;
  localparam int DRAIN_TO_DONE = 14;

  typedef struct {
    int unsigned due;
    logic [31:0] exp;
    logic [7:0]  sign;
  } item_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_last;
  logic [255:0] in_exp, dataflow_out;
  logic [63:0]  in_sign, sign_flow_out;
  logic [7:0]   col_valid;
  logic         busy, tile_done;

  item_t       lane_q [W][$];
  int unsigned done_q[$];
  int unsigned ecnt = 0;
  int          errors = 0;
  int          checks = 0;

  j_term_skew_feeder #(
    .SUBARRAY_WIDTH     (8),
    .SUBARRAY_HEIGHT    (8),
    .NUM_COMBINED_TERMS (8),
    .NUM_BIT_EXPONENT   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .in_exp        (in_exp),
    .in_sign       (in_sign),
    .dataflow_out  (dataflow_out),
    .sign_flow_out (sign_flow_out),
    .col_valid     (col_valid),
    .busy          (busy),
    .tile_done     (tile_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, ecnt);
    end
  endtask

  function automatic logic [255:0] pat_exp(input int tag);
    logic [255:0] r;
    for (int i = 0; i < W; i++) r[i*TE +: TE] = {16'(tag), 8'(i), 8'h5A};
    return r;
  endfunction

  function automatic logic [63:0] pat_sign(input int tag);
    logic [63:0] r;
    for (int i = 0; i < W; i++) r[i*T +: T] = 8'((tag << 3) ^ i);
    return r;
  endfunction

  // Drive one cycle of input; record expected lane outputs when accepted.
  task automatic drive(input logic v, input logic last, input logic [255:0] e,
                       input logic [63:0] s, output logic acc);
    item_t it;
    @(negedge clk);
    #1;
    in_valid = v; in_last = last; in_exp = e; in_sign = s;
    #2;
    acc = v && in_ready;
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        it.due  = ecnt + 1 + i;
        it.exp  = e[i*TE +: TE];
        it.sign = s[i*T +: T];
        lane_q[i].push_back(it);
      end
      if (last) done_q.push_back(ecnt + 1 + DRAIN_TO_DONE);
    end
  endtask

  task automatic idle_cycle();
    logic a;
    drive(1'b0, 1'b0, '0, '0, a);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 60; n++) begin
      idle_cycle();
      if (!busy) break;
    end
    chk(name, busy, 0);
  endtask

  // Monitor: pop per-lane expectations whenever a lane presents a valid column.
  always @(negedge clk) begin
    item_t it;
    logic [31:0] e;
    logic [7:0]  s;
    if (!reset) begin
      for (int i = 0; i < W; i++) begin
        e = dataflow_out[i*TE +: TE];
        s = sign_flow_out[i*T +: T];
        if (col_valid[i]) begin
          if (lane_q[i].size() == 0) begin
            chk("lane_unexpected_valid", {56'd0, 8'(i)}, 64'hFF);
          end else begin
            it = lane_q[i].pop_front();
            chk("lane_timing", ecnt, it.due);
            chk("lane_data", {s, e}, {it.sign, it.exp});
          end
        end else begin
          chk("bubble_zero", {s, e}, 0);
          if (lane_q[i].size() > 0 && lane_q[i][0].due <= ecnt) begin
            it = lane_q[i].pop_front();
            chk("lane_missing_valid", ecnt, it.due);
          end
        end
      end
      if (tile_done) begin
        if (done_q.size() == 0) chk("tile_done_unexpected", 1, 0);
        else chk("tile_done_timing", ecnt, done_q.pop_front());
      end else if (done_q.size() > 0 && done_q[0] <= ecnt) begin
        chk("tile_done_missing", ecnt, done_q.pop_front());
      end
    end
  end

  initial begin
    logic acc;
    logic [255:0] e;
    logic [63:0]  s;
    int sent, tries;

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_exp = '0; in_sign = '0;
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_col_valid", col_valid, 0);
    chk("reset_tile_done", tile_done, 0);
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_busy", busy, 0);

    // Skew + single-vector tile: column i carries exp=i+1, sign bit i.
    for (int i = 0; i < W; i++) begin
      e[i*TE +: TE] = 32'(i + 1);
      s[i*T +: T]   = 8'(1 << i);
    end
    drive(1'b1, 1'b1, e, s, acc);
    chk("skew_accept", acc, 1);
    idle_cycle();
    chk("single_direct_drain_ready", in_ready, 0);
    chk("single_direct_drain_busy", busy, 1);
    wait_idle("single_idle");
    chk("single_ready_after", in_ready, 1);

    // Back-to-back: 16 vectors, then in_valid held high through the drain.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, k == 15, pat_exp(k), pat_sign(k), acc);
      chk("b2b_accept", acc, 1);
    end
    for (int j = 0; j < 15; j++) begin
      drive(1'b1, 1'b1, pat_exp(200), pat_sign(200), acc);
      chk("b2b_drain_hold_off", {acc, in_ready}, 2'b00);
    end
    drive(1'b1, 1'b1, pat_exp(201), pat_sign(201), acc);
    chk("b2b_accept_after_idle", acc, 1);
    wait_idle("b2b_idle");

    // Underflow: two-cycle gap in the middle of a tile.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, k == 5, pat_exp(300 + k), pat_sign(300 + k), acc);
      chk("uf_accept", acc, 1);
      if (k == 2) begin
        idle_cycle();
        idle_cycle();
      end
    end
    wait_idle("uf_idle");

    // Reset mid-stream: in-flight vectors are flushed with no tile_done.
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, pat_exp(400 + k), pat_sign(400 + k), acc);
    @(negedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < W; i++) lane_q[i].delete();
    done_q.delete();
    #1;
    chk("midrst_outputs", {col_valid, busy, tile_done, in_ready}, 0);
    chk("midrst_data", {dataflow_out[63:0] | dataflow_out[255:192], sign_flow_out}, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_release_ready", in_ready, 1);
    chk("midrst_release_busy", busy, 0);

    // Ordering: 64 tagged vectors, random in_valid, tile ends every 16 tags.
    sent = 0;
    tries = 0;
    while (sent < 64 && tries < 3000) begin
      drive($urandom_range(0, 3) != 0, (sent % 16) == 15, pat_exp(500 + sent), pat_sign(500 + sent), acc);
      if (acc) sent++;
      tries++;
    end
    chk("order_all_sent", sent, 64);
    wait_idle("order_idle");

    for (int n = 0; n < 25; n++) idle_cycle();
    for (int i = 0; i < W; i++) chk("lane_queue_empty", lane_q[i].size(), 0);
    chk("done_queue_empty", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
